integrate_dump: RTL

Parametrised integrate-and-dump accumulator: each accepted input sample is scaled by a constant gain and summed over a fixed window of WIN accepted samples. The window sum is then presented on a valid/ready output register, and the next window starts with no idle cycle. It is the next generation of the fixed ×25, 4-cycle integrator. It adds configurable width, gain and window length, input qualification, output back-pressure with overrun detection, and optional saturation. It sits between a sampled data source and a downstream consumer of windowed sums.

---
 rtl/integrate_dump.sv | 71 +++++++
 1 files changed

// File: rtl/integrate_dump.sv
// integrate_dump: scaled integrate-and-dump over WIN accepted samples with valid/ready output.
// Define INTEGRATE_DUMP_SAT_EN to clamp sums at 2^ACC_W-1 instead of wrapping.
module integrate_dump #(
  parameter int IN_W = 4,
  parameter int GAIN = 25,
  parameter int WIN = 4,
  parameter int ACC_W = 13,
  localparam int CW = $clog2(WIN),
  localparam int PW = IN_W + $clog2(GAIN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  x,
  output logic [ACC_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             overrun,
  output logic             sat_hit,
  output logic [CW-1:0]    win_cnt
);
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_q, acc_d, y_q, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y_valid_q, overrun_q, sat_hit_q, sat, accept, dump;

  assign prod = PW'(GAIN) * PW'(x);
`ifdef INTEGRATE_DUMP_SAT_EN
  logic [ACC_W:0] sum_w;
  assign sum_w = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};
  assign sum   = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
  assign sat   = sum_w[ACC_W];
`else
  assign sum = acc_q + ACC_W'(prod);
  assign sat = 1'b0;
`endif

  assign accept = in_valid & ~clr;
  assign dump   = accept & (cnt_q == CW'(WIN - 1));

  always_comb begin
    acc_d = clr ? '0 : accept ? (dump ? '0 : sum) : acc_q;
    cnt_d = clr ? '0 : accept ? (dump ? '0 : cnt_q + CW'(1)) : cnt_q;
  end

  // A dump keeps y_valid high even when the old result is consumed on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      sat_hit_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_q       <= dump ? sum : y_q;
      y_valid_q <= dump | (y_valid_q & ~y_ready);
      overrun_q <= overrun_q | (dump & y_valid_q & ~y_ready);
      sat_hit_q <= sat_hit_q | (accept & sat);
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;
  assign sat_hit = sat_hit_q;
  assign win_cnt = cnt_q;
endmodule
